operand_a_stage: RTL and testbench

Registered, parametrised successor to the operand-A selector in the execute path. It picks operand A from four sources: register value, PC increment constant, sign-extended immediate, or shifted immediate. Register-sourced operands are forwarded from the EX and MEM stages. The chosen word is held in a one-entry pipeline register behind a valid/ready handshake, with stall and flush support. The block sits between decode and the ALU input.

---
 rtl/oper_pkg.sv | 24 ++
 rtl/operand_mux.sv | 71 +++++++
 rtl/operand_a_stage.sv | 101 ++++++++++
 tb/tb_operand_a_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/oper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oper_pkg
//  Description : Shared constants for the operand-A stage: select and
//                forwarding-hit encodings, register index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package oper_pkg;

  localparam int unsigned REG_IDX_W = 5;

  // Operand source select encodings
  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_INC  = 2'b01;
  localparam logic [1:0] SEL_EXT  = 2'b10;
  localparam logic [1:0] SEL_DESP = 2'b11;

  // Forwarding hit encodings (debug output)
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage : oper_pkg
`default_nettype wire

// File: rtl/operand_mux.sv
`default_nettype none
// ============================================================================
//  Module      : operand_mux
//  Description : Combinational operand-A source selection: register value
//                with EX/MEM forwarding, increment constant, sign-extended
//                immediate, or sign-extended immediate shifted left.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_mux
  import oper_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned INC_VAL = 4,
  parameter int unsigned DESP_SH = 2
) (
  input  logic [1:0]           sel_oper_i,
  input  logic [WIDTH-1:0]     reg_value_i,
  input  logic [REG_IDX_W-1:0] reg_addr_i,
  input  logic [IMM_W-1:0]     imm_i,
  input  logic                 fwd_ex_en_i,
  input  logic [REG_IDX_W-1:0] fwd_ex_addr_i,
  input  logic [WIDTH-1:0]     fwd_ex_data_i,
  input  logic                 fwd_mem_en_i,
  input  logic [REG_IDX_W-1:0] fwd_mem_addr_i,
  input  logic [WIDTH-1:0]     fwd_mem_data_i,
  output logic [WIDTH-1:0]     oper_o,
  output logic [1:0]           hit_o
);

  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_reg_fwd;
  logic [1:0]       w_hit;

  // A zero-width replication is illegal, so the equal-width case is split out
  if (WIDTH > IMM_W) begin : g_ext_wide
    assign w_sext = {{(WIDTH - IMM_W){imm_i[IMM_W-1]}}, imm_i};
  end else begin : g_ext_equal
    assign w_sext = imm_i;
  end

  // Forwarding: only for register selects and never for index 0; EX wins over MEM
  always_comb begin
    w_reg_fwd = reg_value_i;
    w_hit     = FWD_NONE;
    if (sel_oper_i == SEL_REG && reg_addr_i != '0) begin
      if (fwd_ex_en_i && fwd_ex_addr_i == reg_addr_i) begin
        w_reg_fwd = fwd_ex_data_i;
        w_hit     = FWD_EX;
      end else if (fwd_mem_en_i && fwd_mem_addr_i == reg_addr_i) begin
        w_reg_fwd = fwd_mem_data_i;
        w_hit     = FWD_MEM;
      end
    end
  end

  // Final source select; shifted-out upper bits are simply truncated
  always_comb begin
    oper_o = w_reg_fwd;
    hit_o  = w_hit;
    case (sel_oper_i)
      SEL_REG:  oper_o = w_reg_fwd;
      SEL_INC:  oper_o = WIDTH'(INC_VAL);
      SEL_EXT:  oper_o = w_sext;
      SEL_DESP: oper_o = w_sext << DESP_SH;
      default:  oper_o = w_reg_fwd;
    endcase
  end

endmodule : operand_mux
`default_nettype wire

// File: rtl/operand_a_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_a_stage
//  Description : Registered operand-A stage between decode and the ALU.
//                One-entry valid/ready pipeline register with stall and
//                flush; source selection lives in operand_mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_a_stage
  import oper_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned INC_VAL = 4,
  parameter int unsigned DESP_SH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           sel_oper_i,
  input  logic [WIDTH-1:0]     reg_value_i,
  input  logic [REG_IDX_W-1:0] reg_addr_i,
  input  logic [IMM_W-1:0]     imm_i,
  input  logic                 fwd_ex_en_i,
  input  logic [REG_IDX_W-1:0] fwd_ex_addr_i,
  input  logic [WIDTH-1:0]     fwd_ex_data_i,
  input  logic                 fwd_mem_en_i,
  input  logic [REG_IDX_W-1:0] fwd_mem_addr_i,
  input  logic [WIDTH-1:0]     fwd_mem_data_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     output_a_o,
  output logic [1:0]           fwd_hit_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] output_a_q;
  logic [1:0]       fwd_hit_q;
  logic [WIDTH-1:0] w_next_oper;
  logic [1:0]       w_next_hit;
  logic             w_accept;

  operand_mux #(
    .WIDTH   (WIDTH),
    .IMM_W   (IMM_W),
    .INC_VAL (INC_VAL),
    .DESP_SH (DESP_SH)
  ) u_mux (
    .sel_oper_i     (sel_oper_i),
    .reg_value_i    (reg_value_i),
    .reg_addr_i     (reg_addr_i),
    .imm_i          (imm_i),
    .fwd_ex_en_i    (fwd_ex_en_i),
    .fwd_ex_addr_i  (fwd_ex_addr_i),
    .fwd_ex_data_i  (fwd_ex_data_i),
    .fwd_mem_en_i   (fwd_mem_en_i),
    .fwd_mem_addr_i (fwd_mem_addr_i),
    .fwd_mem_data_i (fwd_mem_data_i),
    .oper_o         (w_next_oper),
    .hit_o          (w_next_hit)
  );

  // Ready ignores flush on purpose: decode is flushed alongside and drops its handshake
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign w_accept   = in_valid_i && in_ready_o && !flush_i;

  // Valid next-state: flush clears, accept sets, consume without accept clears
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline register: operand and hit code only change on accept, so stalls freeze them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      output_a_q  <= '0;
      fwd_hit_q   <= FWD_NONE;
    end else begin
      out_valid_q <= out_valid_d;
      if (w_accept) begin
        output_a_q <= w_next_oper;
        fwd_hit_q  <= w_next_hit;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign output_a_o  = output_a_q;
  assign fwd_hit_o   = fwd_hit_q;

endmodule : operand_a_stage
`default_nettype wire

// File: tb/tb_operand_a_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_a_stage
//  Description : Directed self-checking bench for operand_a_stage, default
//                32-bit instance plus a 16-bit parameter variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_a_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  // 32-bit instance signals
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  sel_oper, fwd_hit;
  logic [31:0] reg_value, fwd_ex_data, fwd_mem_data, output_a;
  logic [4:0]  reg_addr, fwd_ex_addr, fwd_mem_addr;
  logic [15:0] imm;
  logic        fwd_ex_en, fwd_mem_en;
  // 16-bit instance signals
  logic        b_in_valid, b_in_ready, b_out_valid;
  logic [1:0]  b_sel, b_hit;
  logic [7:0]  b_imm;
  logic [15:0] b_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_a_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .sel_oper_i     (sel_oper),
    .reg_value_i    (reg_value),
    .reg_addr_i     (reg_addr),
    .imm_i          (imm),
    .fwd_ex_en_i    (fwd_ex_en),
    .fwd_ex_addr_i  (fwd_ex_addr),
    .fwd_ex_data_i  (fwd_ex_data),
    .fwd_mem_en_i   (fwd_mem_en),
    .fwd_mem_addr_i (fwd_mem_addr),
    .fwd_mem_data_i (fwd_mem_data),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .output_a_o     (output_a),
    .fwd_hit_o      (fwd_hit)
  );

  operand_a_stage #(
    .WIDTH   (16),
    .IMM_W   (8),
    .INC_VAL (2),
    .DESP_SH (1)
  ) dut16 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (b_in_valid),
    .in_ready_o     (b_in_ready),
    .sel_oper_i     (b_sel),
    .reg_value_i    (16'h0000),
    .reg_addr_i     (5'd0),
    .imm_i          (b_imm),
    .fwd_ex_en_i    (1'b0),
    .fwd_ex_addr_i  (5'd0),
    .fwd_ex_data_i  (16'h0000),
    .fwd_mem_en_i   (1'b0),
    .fwd_mem_addr_i (5'd0),
    .fwd_mem_data_i (16'h0000),
    .flush_i        (1'b0),
    .out_valid_o    (b_out_valid),
    .out_ready_i    (1'b1),
    .output_a_o     (b_out),
    .fwd_hit_o      (b_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    sel_oper = 2'b00; reg_value = '0; reg_addr = '0; imm = '0;
    fwd_ex_en = 1'b0; fwd_ex_addr = '0; fwd_ex_data = '0;
    fwd_mem_en = 1'b0; fwd_mem_addr = '0; fwd_mem_data = '0;
    b_in_valid = 1'b0; b_sel = 2'b00; b_imm = '0;

    // Reset held for two edges
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_output_a", output_a, 32'h0);
    chk("rst_fwd_hit", {30'd0, fwd_hit}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst16_out", {16'd0, b_out}, 32'd0);

    // Back-to-back accepts over every select; 16-bit variant runs alongside
    in_valid = 1'b1; sel_oper = 2'b00; reg_value = 32'h12345678; reg_addr = 5'd3;
    b_in_valid = 1'b1; b_sel = 2'b11; b_imm = 8'hC0;
    tick();
    chk("sel00_valid", {31'd0, out_valid}, 32'd1);
    chk("sel00_data", output_a, 32'h12345678);
    chk("sel00_hit", {30'd0, fwd_hit}, 32'd0);
    chk("w16_sel11", {16'd0, b_out}, 32'h0000FF80);
    sel_oper = 2'b01; b_sel = 2'b01;
    tick();
    chk("sel01_valid", {31'd0, out_valid}, 32'd1);
    chk("sel01_data", output_a, 32'h00000004);
    chk("w16_sel01", {16'd0, b_out}, 32'h00000002);
    b_in_valid = 1'b0;
    sel_oper = 2'b10; imm = 16'hFFFE;
    tick();
    chk("sel10_valid", {31'd0, out_valid}, 32'd1);
    chk("sel10_data", output_a, 32'hFFFFFFFE);
    chk("w16_drained", {31'd0, b_out_valid}, 32'd0);
    sel_oper = 2'b11; imm = 16'h8001;
    tick();
    chk("sel11_valid", {31'd0, out_valid}, 32'd1);
    chk("sel11_data", output_a, 32'hFFFE0004);

    // Forwarding priority: EX over MEM
    sel_oper = 2'b00; reg_value = 32'h12345678; reg_addr = 5'd7;
    fwd_ex_en = 1'b1; fwd_ex_addr = 5'd7; fwd_ex_data = 32'hAAAA0000;
    fwd_mem_en = 1'b1; fwd_mem_addr = 5'd7; fwd_mem_data = 32'hBBBB0000;
    tick();
    chk("fwd_ex_data", output_a, 32'hAAAA0000);
    chk("fwd_ex_hit", {30'd0, fwd_hit}, 32'd1);
    // MEM only
    fwd_ex_en = 1'b0;
    tick();
    chk("fwd_mem_data", output_a, 32'hBBBB0000);
    chk("fwd_mem_hit", {30'd0, fwd_hit}, 32'd2);
    // Index 0 never forwards
    reg_addr = 5'd0; fwd_ex_en = 1'b1; fwd_ex_addr = 5'd0; fwd_mem_addr = 5'd0;
    tick();
    chk("fwd_r0_data", output_a, 32'h12345678);
    chk("fwd_r0_hit", {30'd0, fwd_hit}, 32'd0);
    // Non-register select ignores a matching forward
    sel_oper = 2'b01; reg_addr = 5'd0;
    tick();
    chk("fwd_sel01_data", output_a, 32'h00000004);
    chk("fwd_sel01_hit", {30'd0, fwd_hit}, 32'd0);
    fwd_ex_en = 1'b0; fwd_mem_en = 1'b0;

    // Stall: hold 0x11 while 0x22 waits
    sel_oper = 2'b00; reg_value = 32'h11; reg_addr = 5'd4;
    tick();
    chk("stall_load", output_a, 32'h11);
    out_ready = 1'b0; reg_value = 32'h22;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_data", output_a, 32'h11);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("stall_next_data", output_a, 32'h22);
    chk("stall_next_valid", {31'd0, out_valid}, 32'd1);

    // Flush beats a simultaneous request
    flush = 1'b1; reg_value = 32'h33;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_not_loaded", output_a, 32'h22);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_idle_valid", {31'd0, out_valid}, 32'd0);

    // Consume without a new accept clears valid
    in_valid = 1'b1; reg_value = 32'h44;
    tick();
    chk("consume_load", output_a, 32'h44);
    in_valid = 1'b0;
    tick();
    chk("consume_clear", {31'd0, out_valid}, 32'd0);

    // Reset during a stall discards the held operand
    in_valid = 1'b1; reg_value = 32'h55;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_data", output_a, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_operand_a_stage
`default_nettype wire
